instr_decoder: RTL and testbench

INSTR_DECODER -- requirements
Module: instr_decoder

---
 rtl/instr_decoder_pkg.sv | 35 +++
 rtl/instr_field_decode.sv | 57 +++++
 rtl/instr_decoder.sv | 139 +++++++++++++
 tb/tb_instr_decoder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_decoder_pkg.sv
// instr_decoder_pkg: shared opcodes, FSM encoding, PC register index and IR field positions
package instr_decoder_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_HALTED = 3'd4
    } state_e;

    localparam logic [3:0] OP_ALU_MAX = 4'h7;
    localparam logic [3:0] OP_LDI     = 4'h8;
    localparam logic [3:0] OP_NOP_MIN = 4'h9;
    localparam logic [3:0] OP_NOP_MAX = 4'hD;
    localparam logic [3:0] OP_BR      = 4'hE;
    localparam logic [3:0] OP_HALT    = 4'hF;

    localparam logic [2:0] PC_REG = 3'd7;

    localparam int OPC_HI  = 15;
    localparam int OPC_LO  = 12;
    localparam int RD_HI   = 11;
    localparam int RD_LO   = 9;
    localparam int RN_HI   = 8;
    localparam int RN_LO   = 6;
    localparam int RM_HI   = 5;
    localparam int RM_LO   = 3;
    localparam int RX_HI   = 2;
    localparam int RX_LO   = 0;
    localparam int IMM9_HI = 8;
    localparam int IMM9_LO = 0;
    localparam int IMM9_W  = 9;

endpackage

// File: rtl/instr_field_decode.sv
// instr_field_decode: combinational IR decoder producing register selects, Alu_op,
// extended immediate and per-class write / PC-increment / halt flags.
//   ir      : instruction register
//   rn..rd  : register selects (rd forced to the PC register for BR)
//   alu_op  : execute-unit operation
//   imm     : zero-extended (LDI), sign-extended (BR) or zero immediate
//   is_halt : HALT opcode
//   wr_en   : instruction writes a register in WB
//   inc_en  : instruction increments the PC in WB
module instr_field_decode
    import instr_decoder_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int REG_SEL_W = 3
) (
    input  logic [DATA_W-1:0]    ir,
    output logic [REG_SEL_W-1:0] rn,
    output logic [REG_SEL_W-1:0] rm,
    output logic [REG_SEL_W-1:0] rx,
    output logic [REG_SEL_W-1:0] rd,
    output logic [3:0]           alu_op,
    output logic [DATA_W-1:0]    imm,
    output logic                 is_halt,
    output logic                 wr_en,
    output logic                 inc_en
);

    logic [3:0]        opc;
    logic [IMM9_W-1:0] imm9;
    logic [2:0]        rd_field;
    logic              is_alu;
    logic              is_ldi;
    logic              is_br;
    logic              is_nop;

    always_comb begin
        opc      = ir[OPC_HI:OPC_LO];
        imm9     = ir[IMM9_HI:IMM9_LO];
        rd_field = ir[RD_HI:RD_LO];
        is_alu   = opc <= OP_ALU_MAX;
        is_ldi   = opc == OP_LDI;
        is_br    = opc == OP_BR;
        is_nop   = opc >= OP_NOP_MIN && opc <= OP_NOP_MAX;
        is_halt  = opc == OP_HALT;
        rn       = REG_SEL_W'(ir[RN_HI:RN_LO]);
        rm       = REG_SEL_W'(ir[RM_HI:RM_LO]);
        rx       = REG_SEL_W'(ir[RX_HI:RX_LO]);
        rd       = REG_SEL_W'(is_br ? PC_REG : rd_field);
        alu_op   = opc;
        imm      = is_ldi ? {{(DATA_W-IMM9_W){1'b0}}, imm9} :
                   is_br  ? {{(DATA_W-IMM9_W){imm9[IMM9_W-1]}}, imm9} : '0;
        wr_en    = is_alu || is_ldi || is_br;
        // A register write to the PC replaces the increment.
        inc_en   = ((is_alu || is_ldi) && rd_field != PC_REG) || is_nop;
    end

endmodule

// File: rtl/instr_decoder.sv
// instr_decoder: fetch/decode/exec/writeback sequencer with registered decode outputs.
//   clk, Reset     : clock, asynchronous active-low reset
//   PC             : current PC, forwarded as the fetch address
//   Imem_*         : instruction fetch handshake (req/addr out, valid/rdata in)
//   Rn, Rm, Rx, Rd : register read selects and write select
//   Rw, Pc_inc     : one-cycle writeback strobes
//   Alu_op, Imm    : operation and extended immediate for execute
//   Halt           : sticky halt indicator
module instr_decoder
    import instr_decoder_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int REG_SEL_W = 3
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic [DATA_W-1:0]    PC,
    output logic                 Imem_req,
    output logic [DATA_W-1:0]    Imem_addr,
    input  logic                 Imem_valid,
    input  logic [DATA_W-1:0]    Imem_rdata,
    output logic [REG_SEL_W-1:0] Rn,
    output logic [REG_SEL_W-1:0] Rm,
    output logic [REG_SEL_W-1:0] Rx,
    output logic [REG_SEL_W-1:0] Rd,
    output logic                 Rw,
    output logic [3:0]           Alu_op,
    output logic [DATA_W-1:0]    Imm,
    output logic                 Pc_inc,
    output logic                 Halt
);

    state_e                state_q, state_d;
    logic [DATA_W-1:0]     ir_q, ir_d;
    logic [REG_SEL_W-1:0]  rn_q, rn_d, rm_q, rm_d, rx_q, rx_d, rd_q, rd_d;
    logic [3:0]            alu_op_q, alu_op_d;
    logic [DATA_W-1:0]     imm_q, imm_d;
    logic                  rw_q, rw_d, pc_inc_q, pc_inc_d, halt_q, halt_d;

    logic [REG_SEL_W-1:0]  dec_rn, dec_rm, dec_rx, dec_rd;
    logic [3:0]            dec_alu_op;
    logic [DATA_W-1:0]     dec_imm;
    logic                  dec_halt, dec_wr, dec_inc;

    instr_field_decode #(.DATA_W(DATA_W), .REG_SEL_W(REG_SEL_W)) u_field_decode (
        .ir      (ir_q),
        .rn      (dec_rn),
        .rm      (dec_rm),
        .rx      (dec_rx),
        .rd      (dec_rd),
        .alu_op  (dec_alu_op),
        .imm     (dec_imm),
        .is_halt (dec_halt),
        .wr_en   (dec_wr),
        .inc_en  (dec_inc)
    );

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        rn_d     = rn_q;
        rm_d     = rm_q;
        rx_d     = rx_q;
        rd_d     = rd_q;
        alu_op_d = alu_op_q;
        imm_d    = imm_q;
        halt_d   = halt_q;
        rw_d     = 1'b0;
        pc_inc_d = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (Imem_valid) begin
                    ir_d    = Imem_rdata;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                rn_d     = dec_rn;
                rm_d     = dec_rm;
                rx_d     = dec_rx;
                rd_d     = dec_rd;
                alu_op_d = dec_alu_op;
                imm_d    = dec_imm;
                halt_d   = dec_halt;
                state_d  = dec_halt ? ST_HALTED : ST_EXEC;
            end
            // Strobes are registered here so they appear during the WB cycle.
            ST_EXEC: begin
                rw_d     = dec_wr;
                pc_inc_d = dec_inc;
                state_d  = ST_WB;
            end
            ST_WB:     state_d = ST_FETCH;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= ST_FETCH;
            ir_q     <= '0;
            rn_q     <= '0;
            rm_q     <= '0;
            rx_q     <= '0;
            rd_q     <= '0;
            alu_op_q <= '0;
            imm_q    <= '0;
            rw_q     <= 1'b0;
            pc_inc_q <= 1'b0;
            halt_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            rn_q     <= rn_d;
            rm_q     <= rm_d;
            rx_q     <= rx_d;
            rd_q     <= rd_d;
            alu_op_q <= alu_op_d;
            imm_q    <= imm_d;
            rw_q     <= rw_d;
            pc_inc_q <= pc_inc_d;
            halt_q   <= halt_d;
        end
    end

    assign Imem_req  = state_q == ST_FETCH;
    assign Imem_addr = PC;
    assign Rn        = rn_q;
    assign Rm        = rm_q;
    assign Rx        = rx_q;
    assign Rd        = rd_q;
    assign Rw        = rw_q;
    assign Alu_op    = alu_op_q;
    assign Imm       = imm_q;
    assign Pc_inc    = pc_inc_q;
    assign Halt      = halt_q;

endmodule

// File: tb/tb_instr_decoder.sv
// tb_instr_decoder: table-driven and randomized checks of instr_decoder against a field/timing model
module tb_instr_decoder;

    logic        clk = 1'b0;
    logic        Reset;
    logic [15:0] PC;
    logic        Imem_req;
    logic [15:0] Imem_addr;
    logic        Imem_valid;
    logic [15:0] Imem_rdata;
    logic [2:0]  Rn, Rm, Rx, Rd;
    logic        Rw;
    logic [3:0]  Alu_op;
    logic [15:0] Imm;
    logic        Pc_inc;
    logic        Halt;

    int vectors = 0;
    int miscompares = 0;

    instr_decoder dut (
        .clk        (clk),
        .Reset      (Reset),
        .PC         (PC),
        .Imem_req   (Imem_req),
        .Imem_addr  (Imem_addr),
        .Imem_valid (Imem_valid),
        .Imem_rdata (Imem_rdata),
        .Rn         (Rn),
        .Rm         (Rm),
        .Rx         (Rx),
        .Rd         (Rd),
        .Rw         (Rw),
        .Alu_op     (Alu_op),
        .Imm        (Imm),
        .Pc_inc     (Pc_inc),
        .Halt       (Halt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic [2:0]  rd;
        logic [15:0] imm;
        logic [3:0]  alu;
        logic        rw;
        logic        inc;
        logic        halt;
        logic        chk_op;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference decode from the instruction-set rules, using plain arithmetic.
    function automatic vec_t ref_model(input logic [15:0] ins);
        vec_t v;
        int opc  = int'(ins) / 4096;
        int rdf  = (int'(ins) / 512) % 8;
        int imm9 = int'(ins) % 512;
        v.instr  = ins;
        v.rd     = 3'(rdf);
        v.imm    = 16'd0;
        v.alu    = 4'(opc);
        v.rw     = 1'b0;
        v.inc    = 1'b0;
        v.halt   = 1'b0;
        v.chk_op = 1'b1;
        if (opc <= 7) begin
            v.rw  = 1'b1;
            v.inc = rdf != 7;
        end else if (opc == 8) begin
            v.imm = 16'(imm9);
            v.rw  = 1'b1;
            v.inc = rdf != 7;
        end else if (opc == 14) begin
            v.rd  = 3'd7;
            v.imm = 16'(imm9 >= 256 ? imm9 + 65536 - 512 : imm9);
            v.rw  = 1'b1;
        end else if (opc == 15) begin
            v.halt   = 1'b1;
            v.chk_op = 1'b0;
        end else begin
            v.inc    = 1'b1;
            v.chk_op = 1'b0;
        end
        return v;
    endfunction

    task automatic garbage();
        Imem_valid = 1'($urandom_range(0, 1));
        Imem_rdata = 16'($urandom);
    endtask

    task automatic chk_fields(input string tag, input vec_t e);
        chk({tag, " Rd"}, Rd, e.rd);
        chk({tag, " Rn"}, Rn, e.instr[8:6]);
        chk({tag, " Rm"}, Rm, e.instr[5:3]);
        chk({tag, " Rx"}, Rx, e.instr[2:0]);
        if (e.chk_op) begin
            chk({tag, " Alu_op"}, Alu_op, e.alu);
            chk({tag, " Imm"}, Imm, e.imm);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " Imem_req"}, Imem_req, 1'b1);
        chk({tag, " Rw"}, Rw, 1'b0);
        chk({tag, " Pc_inc"}, Pc_inc, 1'b0);
        chk({tag, " Halt"}, Halt, 1'b0);
        chk({tag, " regsel"}, {Rn, Rm, Rx, Rd}, 12'h000);
        chk({tag, " Alu_op"}, Alu_op, 4'h0);
        chk({tag, " Imm"}, Imm, 16'h0000);
    endtask

    // Called just after the accepting negedge drive; checks DECODE, EXEC, WB and the return to FETCH.
    task automatic post(input vec_t e);
        @(negedge clk);
        chk("decode Imem_req", Imem_req, 1'b0);
        chk("decode Rw/Pc_inc", {Rw, Pc_inc}, 2'b00);
        chk("decode Halt", Halt, 1'b0);
        garbage();
        @(negedge clk);
        if (e.halt) begin
            for (int i = 0; i < 6; i++) begin
                chk("halted Halt", Halt, 1'b1);
                chk("halted Imem_req", Imem_req, 1'b0);
                chk("halted Rw/Pc_inc", {Rw, Pc_inc}, 2'b00);
                garbage();
                @(negedge clk);
            end
            return;
        end
        chk("exec Imem_req", Imem_req, 1'b0);
        chk("exec Rw/Pc_inc", {Rw, Pc_inc}, 2'b00);
        chk_fields("exec", e);
        garbage();
        @(negedge clk);
        chk("wb Imem_req", Imem_req, 1'b0);
        chk("wb Rw", Rw, e.rw);
        chk("wb Pc_inc", Pc_inc, e.inc);
        chk_fields("wb", e);
        Imem_valid = 1'b0;
        @(negedge clk);
        chk("refetch Imem_req", Imem_req, 1'b1);
        chk("refetch Rw/Pc_inc", {Rw, Pc_inc}, 2'b00);
        chk_fields("refetch", e);
    endtask

    // At a negedge in FETCH: stall wait_n cycles, then present the instruction.
    task automatic issue(input vec_t e, input int wait_n);
        for (int i = 0; i < wait_n; i++) begin
            Imem_valid = 1'b0;
            Imem_rdata = 16'($urandom);
            PC = 16'($urandom);
            #1;
            chk("stall Imem_req", Imem_req, 1'b1);
            chk("stall Imem_addr", Imem_addr, PC);
            chk("stall Rw", Rw, 1'b0);
            @(negedge clk);
        end
        PC = 16'($urandom);
        Imem_valid = 1'b1;
        Imem_rdata = e.instr;
        #1;
        chk("fetch Imem_req", Imem_req, 1'b1);
        chk("fetch Imem_addr", Imem_addr, PC);
        post(e);
    endtask

    task automatic pulse_reset();
        Reset = 1'b0;
        #1;
        chk_reset_vals("reset-async");
        @(negedge clk);
        chk_reset_vals("reset-held");
        Reset = 1'b1;
        Imem_valid = 1'b0;
    endtask

    vec_t vecs [12];

    initial begin
        vec_t e;
        vecs[0]  = '{16'h8005, 3'd0, 16'h0005, 4'h8, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{16'hEFFF, 3'd7, 16'hFFFF, 4'hE, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{16'h1250, 3'd1, 16'h0000, 4'h1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{16'h0E00, 3'd7, 16'h0000, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{16'h81FF, 3'd0, 16'h01FF, 4'h8, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{16'h8FFF, 3'd7, 16'h01FF, 4'h8, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{16'hE100, 3'd7, 16'hFF00, 4'hE, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{16'hE0FF, 3'd7, 16'h00FF, 4'hE, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{16'h9ABC, 3'd5, 16'h0000, 4'h9, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{16'hD000, 3'd0, 16'h0000, 4'hD, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{16'h7123, 3'd0, 16'h0000, 4'h7, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{16'h6C00, 3'd6, 16'h0000, 4'h6, 1'b1, 1'b1, 1'b0, 1'b1};

        Reset = 1'b0;
        PC = 16'h0000;
        Imem_valid = 1'b0;
        Imem_rdata = 16'h0000;
        repeat (2) @(negedge clk);
        chk_reset_vals("por");

        // Release with valid already high: fetch is requested in the first cycle.
        Reset = 1'b1;
        PC = 16'h0000;
        Imem_valid = 1'b1;
        Imem_rdata = vecs[0].instr;
        #1;
        chk("release Imem_req", Imem_req, 1'b1);
        chk("release Imem_addr", Imem_addr, 16'h0000);
        post(vecs[0]);

        // Long stall in FETCH.
        issue(vecs[1], 5);

        for (int i = 2; i < 12; i++) issue(vecs[i], i % 3);

        // Reset during EXEC of 0x1250 abandons the instruction.
        PC = 16'h0040;
        Imem_valid = 1'b1;
        Imem_rdata = 16'h1250;
        @(negedge clk);
        Imem_valid = 1'b0;
        @(negedge clk);
        chk("exec-reset precond Rd", Rd, 3'd1);
        pulse_reset();
        #1;
        chk("exec-reset after Rw/Pc_inc", {Rw, Pc_inc}, 2'b00);
        @(negedge clk);
        chk("exec-reset later Rw/Pc_inc", {Rw, Pc_inc}, 2'b00);
        chk("exec-reset Imem_req", Imem_req, 1'b1);

        // Randomized instructions against the reference model (HALT kept for the end).
        for (int i = 0; i < 40; i++) begin
            logic [15:0] ins;
            ins = 16'($urandom);
            if (ins[15:12] == 4'hF) ins[15:12] = 4'($urandom_range(0, 14));
            issue(ref_model(ins), $urandom_range(0, 3));
        end

        // HALT is sticky; only reset recovers.
        issue(ref_model(16'hF000), 1);
        pulse_reset();
        @(negedge clk);
        chk("post-halt Halt", Halt, 1'b0);
        chk("post-halt Imem_req", Imem_req, 1'b1);
        issue(vecs[0], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
